alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 8, operand width; CWIDTH, default 4, command width.
REQ-002 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port ce  input  1  clock enable; 0 freezes state and outputs.
REQ-005 Port mode  input  1  1 = arithmetic command set, 0 = logical command set.
REQ-006 Port cin  input  1  carry-in for ADD_CIN/SUB_CIN.
REQ-007 Port cmd  input  CWIDTH  operation select.
REQ-008 Port inp_valid  input  2  bit0 = opa valid, bit1 = opb valid.
REQ-009 Port opa, opb  input  DWIDTH each  operands.
REQ-010 Port res  output  DWIDTH+2  result, zero-extended; SUB results are two's complement in DWIDTH+2 bits.
REQ-011 Ports cout, oflow, g, e, l, err  output  1 each  carry, unsigned overflow/borrow, greater, equal, less, error.

Function
REQ-012 All outputs SHALL be registered; with ce=1, single-cycle ops sampled at edge N SHALL be visible from edge N+1 onward.
REQ-013 Arithmetic cmds (mode=1): 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP, 9 MUL_INC ((opa+1)*(opb+1)), 10 MUL_SHL ((opa<<1)*opb).
REQ-014 Logical cmds (mode=0): 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B, 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B, 12 ROL_A_B, 13 ROR_A_B.
REQ-015 Any other cmd value SHALL set err=1 and res=0 at the next result update.
REQ-016 cout SHALL be bit DWIDTH of ADD/ADD_CIN/INC results; oflow SHALL be 1 when SUB/SUB_CIN/DEC borrows.
REQ-017 CMP SHALL set exactly one of g/e/l (unsigned compare) and res=0.
REQ-018 Logical results SHALL occupy res[DWIDTH-1:0], with upper bits 0.
REQ-019 ROL/ROR SHALL rotate opa by opb[log2(DWIDTH)-1:0]; any other opb bit set SHALL assert err, and the rotation SHALL still be performed.
REQ-020 Flags not defined by the current op SHALL be 0 on each result update.
REQ-021 FSM states SHALL be IDLE, WAIT_OPND, MUL_S1, MUL_S2.
REQ-022 IDLE, inp_valid=00: no operation; outputs hold.
REQ-023 IDLE, single-operand cmd (INC/DEC/NOT/shift of A or B): executes when its operand's valid bit is set; the other bit is ignored.
REQ-024 IDLE, two-operand cmd with inp_valid=11: executes immediately.
REQ-025 IDLE, two-operand cmd with inp_valid=01 or 10: latch the present operand, cmd, and mode, then go to WAIT_OPND with a 4-bit timer cleared to 0.
REQ-026 WAIT_OPND: cmd/mode inputs are ignored; arrival of the missing operand (or 11) completes the op, and the result is visible the next cycle.
REQ-027 WAIT_OPND timeout: the timer reaches 15 with no arrival (16 waiting cycles) -> err=1, res=0, return to IDLE.
REQ-028 Multiply cmds SHALL go IDLE->MUL_S1->MUL_S2->IDLE, with the result visible 3 edges after the sampling edge.
REQ-029 Multiply results SHALL be truncated to DWIDTH+2 bits.
REQ-030 Inputs presented during MUL_S1/MUL_S2 SHALL be ignored.
REQ-031 ce=0 in any state SHALL freeze state, timer, pipeline registers, and outputs.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, clear the timer and latched operands, and set res=0 and cout=oflow=g=e=l=err=0; rst overrides ce.
REQ-033 rst asserted during WAIT_OPND or a multiply SHALL abort the pending operation with no result produced.

Verification
REQ-034 rst=1 during MUL_S1 -> next cycle all outputs 0; a subsequent ADD 1+1 -> res=2.
REQ-035 mode=1, cmd=0, opa=8'hFF, opb=8'h01, inp_valid=11 -> res=10'h100, cout=1, next cycle.
REQ-036 mode=1, cmd=1, opa=5, opb=7 -> res=10'h3FE, oflow=1; cmd=8, opa=opb=8'h33 -> e=1, g=l=0.
REQ-037 mode=1, cmd=9, opa=3, opb=4 -> res=20 on the third edge after sampling; inputs changed in the gap are ignored.
REQ-038 ADD with inp_valid=01, opa=2, then inp_valid=10, opb=3 five cycles later -> res=5; the same with no opb for 16 cycles -> err=1, res=0.
REQ-039 mode=0, cmd=12, opa=8'h81, opb=8'h11 -> res=8'h03, err=1; cmd=15 -> err=1.

Source files
------------

// File: rtl/alu_core_if.sv
// Bus bundle for alu_core: operand/command inputs, registered result and flags,
// plus the FSM state for observation.
//
// Input qualification: inp_valid[0] marks opa as valid and inp_valid[1] marks
// opb as valid in the cycle they are sampled; there is no back-pressure, so a
// valid operand is consumed on the edge it is presented (when ce=1), except in
// MUL_S1/MUL_S2 where all inputs are ignored.
interface alu_core_if #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 4
);
  logic                ce;
  logic                mode;
  logic                cin;
  logic [CWIDTH-1:0]   cmd;
  logic [1:0]          inp_valid;
  logic [DWIDTH-1:0]   opa;
  logic [DWIDTH-1:0]   opb;
  logic [DWIDTH+1:0]   res;
  logic                cout;
  logic                oflow;
  logic                g;
  logic                e;
  logic                l;
  logic                err;
  logic [1:0]          fsm_state;

  modport master (
    output ce, mode, cin, cmd, inp_valid, opa, opb,
    input  res, cout, oflow, g, e, l, err, fsm_state
  );

  modport slave (
    input  ce, mode, cin, cmd, inp_valid, opa, opb,
    output res, cout, oflow, g, e, l, err, fsm_state
  );
endinterface

// File: rtl/alu_core.sv
// Registered ALU with an operand-collection FSM and a two-stage multiply path.
// All results and flags update together; flags not produced by an op read 0.
// Rotate amounts use the low $clog2(DWIDTH) bits of opb, so DWIDTH must be >= 2.
module alu_core #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 4
) (
  input logic       clk,
  input logic       rst,
  alu_core_if.slave bus
);
  localparam int RW = DWIDTH + 2;
  localparam int SW = $clog2(DWIDTH);
  localparam logic [DWIDTH:0] ONE_X = 1;

  typedef enum logic [1:0] {IDLE, WAIT_OPND, MUL_S1, MUL_S2} state_t;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          cout;
    logic          oflow;
    logic          g;
    logic          e;
    logic          l;
    logic          err;
  } out_t;

  state_t            state_q, state_n;
  logic [3:0]        timer_q, timer_n;
  logic [DWIDTH-1:0] lat_a_q, lat_a_n, lat_b_q, lat_b_n;
  logic [1:0]        lat_have_q, lat_have_n;
  logic [CWIDTH-1:0] lat_cmd_q, lat_cmd_n;
  logic              lat_mode_q, lat_mode_n;
  logic [DWIDTH:0]   mul_x_q, mul_x_n, mul_y_q, mul_y_n;
  out_t              out_q, out_n;
  logic [1:0]        need, arrive;
  logic [DWIDTH-1:0] a_sel, b_sel;
  logic [RW-1:0]     prod;

  // Operand requirement per command: 11 two-operand, 01 A only, 10 B only,
  // 00 undefined command (executes on any valid bit and reports err).
  function automatic logic [1:0] need_mask(input logic m, input logic [CWIDTH-1:0] c);
    logic [1:0] r;
    r = 2'b00;
    if (m) begin
      case (int'(c))
        0, 1, 2, 3, 8, 9, 10: r = 2'b11;
        4, 5:                 r = 2'b01;
        6, 7:                 r = 2'b10;
        default:              r = 2'b00;
      endcase
    end else begin
      case (int'(c))
        0, 1, 2, 3, 4, 5, 12, 13: r = 2'b11;
        6, 8, 9:                  r = 2'b01;
        7, 10, 11:                r = 2'b10;
        default:                  r = 2'b00;
      endcase
    end
    return r;
  endfunction

  function automatic logic is_mul(input logic m, input logic [CWIDTH-1:0] c);
    return m && (int'(c) == 9 || int'(c) == 10);
  endfunction

  // Single-cycle result for every non-multiply command.
  function automatic out_t compute(input logic m, input logic [CWIDTH-1:0] c, input logic ci,
                                   input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
    out_t                o;
    logic [RW-1:0]       ae, be, t;
    logic [DWIDTH-1:0]   lr;
    logic [2*DWIDTH-1:0] rot;
    logic [SW-1:0]       sh;
    o   = '0;
    ae  = RW'(a);
    be  = RW'(b);
    t   = '0;
    lr  = '0;
    rot = '0;
    sh  = b[SW-1:0];
    if (m) begin
      case (int'(c))
        0: begin t = ae + be;              o.res = t; o.cout  = t[DWIDTH]; end
        1: begin t = ae - be;              o.res = t; o.oflow = t[RW-1];   end
        2: begin t = ae + be + RW'(ci);    o.res = t; o.cout  = t[DWIDTH]; end
        3: begin t = ae - be - RW'(ci);    o.res = t; o.oflow = t[RW-1];   end
        4: begin t = ae + RW'(1);          o.res = t; o.cout  = t[DWIDTH]; end
        5: begin t = ae - RW'(1);          o.res = t; o.oflow = t[RW-1];   end
        6: begin t = be + RW'(1);          o.res = t; o.cout  = t[DWIDTH]; end
        7: begin t = be - RW'(1);          o.res = t; o.oflow = t[RW-1];   end
        8: begin o.g = (a > b); o.e = (a == b); o.l = (a < b); end
        default: o.err = 1'b1;
      endcase
    end else begin
      case (int'(c))
        0:  lr = a & b;
        1:  lr = ~(a & b);
        2:  lr = a | b;
        3:  lr = ~(a | b);
        4:  lr = a ^ b;
        5:  lr = ~(a ^ b);
        6:  lr = ~a;
        7:  lr = ~b;
        8:  lr = a >> 1;
        9:  lr = a << 1;
        10: lr = b >> 1;
        11: lr = b << 1;
        12: begin rot = {a, a} << sh; lr = rot[2*DWIDTH-1:DWIDTH]; o.err = ((b >> SW) != '0); end
        13: begin rot = {a, a} >> sh; lr = rot[DWIDTH-1:0];        o.err = ((b >> SW) != '0); end
        default: o.err = 1'b1;
      endcase
      o.res = RW'(lr);
    end
    return o;
  endfunction

  assign prod = RW'(mul_x_q) * RW'(mul_y_q);

  // Next-state, operand latching and result selection.
  always_comb begin
    state_n    = state_q;
    timer_n    = timer_q;
    lat_a_n    = lat_a_q;
    lat_b_n    = lat_b_q;
    lat_have_n = lat_have_q;
    lat_cmd_n  = lat_cmd_q;
    lat_mode_n = lat_mode_q;
    mul_x_n    = mul_x_q;
    mul_y_n    = mul_y_q;
    out_n      = out_q;
    need       = need_mask(bus.mode, bus.cmd);
    arrive     = bus.inp_valid & ~lat_have_q;
    a_sel      = lat_have_q[0] ? lat_a_q : bus.opa;
    b_sel      = lat_have_q[1] ? lat_b_q : bus.opb;
    case (state_q)
      IDLE: begin
        if (bus.inp_valid != 2'b00) begin
          if (need == 2'b11) begin
            if (bus.inp_valid == 2'b11) begin
              if (is_mul(bus.mode, bus.cmd)) begin
                lat_a_n   = bus.opa;
                lat_b_n   = bus.opb;
                lat_cmd_n = bus.cmd;
                state_n   = MUL_S1;
              end else begin
                out_n = compute(bus.mode, bus.cmd, bus.cin, bus.opa, bus.opb);
              end
            end else begin
              lat_a_n    = bus.opa;
              lat_b_n    = bus.opb;
              lat_have_n = bus.inp_valid;
              lat_cmd_n  = bus.cmd;
              lat_mode_n = bus.mode;
              timer_n    = 4'd0;
              state_n    = WAIT_OPND;
            end
          end else if (need == 2'b00 || (need & bus.inp_valid) != 2'b00) begin
            out_n = compute(bus.mode, bus.cmd, bus.cin, bus.opa, bus.opb);
          end
        end
      end
      WAIT_OPND: begin
        if (arrive != 2'b00) begin
          if (is_mul(lat_mode_q, lat_cmd_q)) begin
            lat_a_n = a_sel;
            lat_b_n = b_sel;
            state_n = MUL_S1;
          end else begin
            out_n   = compute(lat_mode_q, lat_cmd_q, bus.cin, a_sel, b_sel);
            state_n = IDLE;
          end
        end else if (timer_q == 4'd15) begin
          out_n     = '0;
          out_n.err = 1'b1;
          state_n   = IDLE;
        end else begin
          timer_n = timer_q + 4'd1;
        end
      end
      MUL_S1: begin
        if (int'(lat_cmd_q) == 9) begin
          mul_x_n = {1'b0, lat_a_q} + ONE_X;
          mul_y_n = {1'b0, lat_b_q} + ONE_X;
        end else begin
          mul_x_n = {lat_a_q, 1'b0};
          mul_y_n = {1'b0, lat_b_q};
        end
        state_n = MUL_S2;
      end
      MUL_S2: begin
        out_n     = '0;
        out_n.res = prod;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      lat_a_q    <= '0;
      lat_b_q    <= '0;
      lat_have_q <= '0;
      lat_cmd_q  <= '0;
      lat_mode_q <= 1'b0;
      mul_x_q    <= '0;
      mul_y_q    <= '0;
      out_q      <= '0;
    end else if (bus.ce) begin
      state_q    <= state_n;
      timer_q    <= timer_n;
      lat_a_q    <= lat_a_n;
      lat_b_q    <= lat_b_n;
      lat_have_q <= lat_have_n;
      lat_cmd_q  <= lat_cmd_n;
      lat_mode_q <= lat_mode_n;
      mul_x_q    <= mul_x_n;
      mul_y_q    <= mul_y_n;
      out_q      <= out_n;
    end
  end

  assign bus.res       = out_q.res;
  assign bus.cout      = out_q.cout;
  assign bus.oflow     = out_q.oflow;
  assign bus.g         = out_q.g;
  assign bus.e         = out_q.e;
  assign bus.l         = out_q.l;
  assign bus.err       = out_q.err;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_alu_core.sv
// Directed and lightly randomised bench for alu_core with an expected-value queue.
module tb_alu_core;
  logic clk;
  logic rst;

  alu_core_if #(.DWIDTH(8), .CWIDTH(4)) bus ();

  alu_core #(.DWIDTH(8), .CWIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [15:0] pk(input logic [9:0] r, input logic co, input logic ov,
                                     input logic gg, input logic ee, input logic ll, input logic er);
    return {r, co, ov, gg, ee, ll, er};
  endfunction

  task automatic push(input string tag, input logic [15:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    logic [15:0] obs, e;
    string       tag;
    obs = {bus.res, bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err};
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    n_total++;
    assert (obs === e) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, e);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] e);
    n_total++;
    assert (bus.fsm_state === e) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got state %0d expected %0d", tag, bus.fsm_state, e);
    end
  endtask

  // driver: advance one active edge and park on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(input logic m, input logic [3:0] c, input logic ci, input logic [1:0] iv,
                    input logic [7:0] a, input logic [7:0] b);
    bus.mode      = m;
    bus.cmd       = c;
    bus.cin       = ci;
    bus.inp_valid = iv;
    bus.opa       = a;
    bus.opb       = b;
    step();
    bus.inp_valid = 2'b00;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [9:0] r;
    int         sel;

    rst = 1'b1;
    bus.ce = 1'b1; bus.mode = 1'b0; bus.cin = 1'b0; bus.cmd = '0;
    bus.inp_valid = 2'b00; bus.opa = '0; bus.opb = '0;
    step();
    step();
    rst = 1'b0;
    push("reset", pk(0, 0, 0, 0, 0, 0, 0)); check();
    check_state("reset_state", 2'd0);

    // arithmetic single-cycle ops
    push("add_ff_01", pk(10'h100, 1, 0, 0, 0, 0, 0));  op(1, 0, 0, 2'b11, 8'hFF, 8'h01); check();
    push("sub_5_7", pk(10'h3FE, 0, 1, 0, 0, 0, 0));    op(1, 1, 0, 2'b11, 8'd5, 8'd7);   check();
    push("add_cin", pk(10'h100, 1, 0, 0, 0, 0, 0));    op(1, 2, 1, 2'b11, 8'h80, 8'h7F); check();
    push("sub_cin", pk(10'h3FF, 0, 1, 0, 0, 0, 0));    op(1, 3, 1, 2'b11, 8'd3, 8'd3);   check();
    push("cmp_eq", pk(0, 0, 0, 0, 1, 0, 0));           op(1, 8, 0, 2'b11, 8'h33, 8'h33); check();
    push("cmp_gt", pk(0, 0, 0, 1, 0, 0, 0));           op(1, 8, 0, 2'b11, 8'h40, 8'h33); check();
    push("cmp_lt", pk(0, 0, 0, 0, 0, 1, 0));           op(1, 8, 0, 2'b11, 8'h10, 8'h33); check();

    // multiply: inputs in the gap are ignored, result on the third edge
    op(1, 9, 0, 2'b11, 8'd3, 8'd4);
    bus.mode = 1'b1; bus.cmd = 4'd0; bus.inp_valid = 2'b11; bus.opa = 8'd7; bus.opb = 8'd7;
    step();
    push("mul_gap_hold", pk(0, 0, 0, 0, 0, 1, 0)); check();
    step();
    bus.inp_valid = 2'b00;
    push("mul_inc", pk(10'd20, 0, 0, 0, 0, 0, 0)); check();
    check_state("mul_done_idle", 2'd0);
    op(1, 10, 0, 2'b11, 8'hFF, 8'hFF);
    step();
    step();
    push("mul_shl_trunc", pk(10'h002, 0, 0, 0, 0, 0, 0)); check();

    // single-operand ops honour only their own valid bit
    push("inc_a", pk(10'h100, 1, 0, 0, 0, 0, 0));   op(1, 4, 0, 2'b01, 8'hFF, 8'h00); check();
    push("dec_b", pk(10'h3FF, 0, 1, 0, 0, 0, 0));   op(1, 7, 0, 2'b10, 8'h00, 8'h00); check();
    push("inc_b_wrong", pk(10'h3FF, 0, 1, 0, 0, 0, 0)); op(1, 6, 0, 2'b01, 8'h00, 8'h10); check();
    push("no_valid", pk(10'h3FF, 0, 1, 0, 0, 0, 0));    op(1, 0, 0, 2'b00, 8'h01, 8'h01); check();

    // logical ops
    push("nand", pk(10'h0CF, 0, 0, 0, 0, 0, 0));    op(0, 1, 0, 2'b11, 8'hF0, 8'h3C); check();
    push("not_a", pk(10'h0F0, 0, 0, 0, 0, 0, 0));   op(0, 6, 0, 2'b01, 8'h0F, 8'h00); check();
    push("shl1_b", pk(10'h002, 0, 0, 0, 0, 0, 0));  op(0, 11, 0, 2'b10, 8'h00, 8'h81); check();
    push("rol_err", pk(10'h003, 0, 0, 0, 0, 0, 1)); op(0, 12, 0, 2'b11, 8'h81, 8'h11); check();
    push("ror", pk(10'h0C0, 0, 0, 0, 0, 0, 0));     op(0, 13, 0, 2'b11, 8'h81, 8'h01); check();
    push("bad_cmd", pk(0, 0, 0, 0, 0, 0, 1));       op(0, 15, 0, 2'b11, 8'h12, 8'h34); check();

    // clock enable low freezes everything
    bus.ce = 1'b0;
    push("ce_hold", pk(0, 0, 0, 0, 0, 0, 1));       op(1, 0, 0, 2'b11, 8'd5, 8'd5); check();
    bus.ce = 1'b1;

    // operand arriving five cycles late; cmd/mode changes meanwhile are ignored
    op(1, 0, 0, 2'b01, 8'd2, 8'd0);
    check_state("wait_entered", 2'd1);
    bus.mode = 1'b0; bus.cmd = 4'd1;
    repeat (4) step();
    push("late_opb", pk(10'd5, 0, 0, 0, 0, 0, 0));  op(0, 5, 0, 2'b10, 8'd0, 8'd3); check();

    // no second operand: 16 waiting cycles then timeout
    op(1, 0, 0, 2'b01, 8'd2, 8'd0);
    repeat (15) step();
    push("wait_hold", pk(10'd5, 0, 0, 0, 0, 0, 0)); check();
    step();
    push("timeout", pk(0, 0, 0, 0, 0, 0, 1)); check();
    check_state("timeout_idle", 2'd0);

    // reset during the multiply aborts it
    op(1, 9, 0, 2'b11, 8'd3, 8'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    push("rst_mul", pk(0, 0, 0, 0, 0, 0, 0)); check();
    step();
    step();
    push("rst_mul_noleak", pk(0, 0, 0, 0, 0, 0, 0)); check();
    push("add_after_rst", pk(10'd2, 0, 0, 0, 0, 0, 0)); op(1, 0, 0, 2'b11, 8'd1, 8'd1); check();

    // random ADD/SUB/AND/XOR against a plain arithmetic model
    for (int i = 0; i < 16; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin
          r = 10'(ra) + 10'(rb);
          push("rand_add", pk(r, r[8], 0, 0, 0, 0, 0)); op(1, 0, 0, 2'b11, ra, rb);
        end
        1: begin
          r = 10'(ra) - 10'(rb);
          push("rand_sub", pk(r, 0, (ra < rb), 0, 0, 0, 0)); op(1, 1, 0, 2'b11, ra, rb);
        end
        2: begin
          push("rand_and", pk(10'(ra & rb), 0, 0, 0, 0, 0, 0)); op(0, 0, 0, 2'b11, ra, rb);
        end
        default: begin
          push("rand_xor", pk(10'(ra ^ rb), 0, 0, 0, 0, 0, 0)); op(0, 4, 0, 2'b11, ra, rb);
        end
      endcase
      check();
    end

    // report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
